ca_rule_sequencer: RTL and testbench

- Upstream control stage for the scrolling elementary-CA renderer. Chooses the 8-bit Wolfram rule the renderer applies and its palette index.
- Inputs are debounced next/prev buttons, a manual rule load and an auto-advance timer. All of them are counted in frames.
- Rule changes are double-buffered and only reach the renderer at a frame boundary, so a frame never mixes rules. Each applied change also pulses a reseed request.

---
 rtl/ca_rule_sequencer_if.sv | 9 +
 rtl/ca_rule_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ca_rule_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ca_rule_sequencer_if.sv
// Manual rule-load channel: valid/data from the sender, ready back from the sequencer.
interface ca_rule_sequencer_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/ca_rule_sequencer.sv
// Selects the Wolfram rule and table index for the CA renderer; every change
// is deferred to a frame_tick so a frame never mixes rules.
module ca_rule_sequencer #(
    parameter int unsigned NUM_RULES       = 8,
    parameter int unsigned FRAMES_PER_RULE = 256,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    localparam int unsigned IW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 auto_en,
    ca_rule_sequencer_if.slave   load,
    output logic [7:0]           rule,
    output logic [IW-1:0]        rule_idx,
    output logic                 seed_req
);
    localparam logic [15:0] FPR = 16'(FRAMES_PER_RULE);
    localparam logic [3:0]  DEB = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {RELEASED, ARM_PRESS, PRESSED, ARM_RELEASE} db_state_t;

    function automatic logic [7:0] init_rule(input int unsigned i);
        case (i)
            0: return 8'd30;
            1: return 8'd110;
            2: return 8'd22;
            3: return 8'd73;
            4: return 8'd90;
            5: return 8'd146;
            6: return 8'd105;
            7: return 8'd102;
            default: return 8'd0;
        endcase
    endfunction

    logic [7:0]    rule_tab [NUM_RULES];
    db_state_t     db_st    [2];
    logic [3:0]    db_cnt   [2];
    logic [1:0]    btn_in;
    logic [1:0]    press_ev;
    logic [15:0]   fcnt;
    logic          pend_load;
    logic [7:0]    pend_data;
    logic          auto_ev;
    logic [IW-1:0] idx_fwd;
    logic [IW-1:0] idx_back;

    assign load.load_ready = !pend_load;

    // Press events are decoded from the pre-update state so the apply logic
    // sees the debouncer result of this same frame_tick.
    always_comb begin
        btn_in   = {btn_prev, btn_next};
        press_ev = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            if (frame_tick && btn_in[b]) begin
                if (db_st[b] == RELEASED && DEB == 4'd1)
                    press_ev[b] = 1'b1;
                if (db_st[b] == ARM_PRESS && (db_cnt[b] + 4'd1) == DEB)
                    press_ev[b] = 1'b1;
            end
        end
        auto_ev  = frame_tick && auto_en && ((fcnt + 16'd1) >= FPR);
        idx_fwd  = rule_idx + IW'(1);
        idx_back = rule_idx - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_RULES; i++)
                rule_tab[i] <= init_rule(i);
            for (int unsigned b = 0; b < 2; b++) begin
                db_st[b]  <= RELEASED;
                db_cnt[b] <= '0;
            end
            fcnt      <= '0;
            pend_load <= 1'b0;
            pend_data <= '0;
            rule_idx  <= '0;
            rule      <= init_rule(0);
            seed_req  <= 1'b0;
        end else begin
            seed_req <= 1'b0;
            if (frame_tick) begin
                for (int unsigned b = 0; b < 2; b++) begin
                    case (db_st[b])
                        RELEASED:
                            if (btn_in[b]) begin
                                if (DEB == 4'd1) begin
                                    db_st[b] <= PRESSED;
                                end else begin
                                    db_st[b]  <= ARM_PRESS;
                                    db_cnt[b] <= 4'd1;
                                end
                            end
                        ARM_PRESS:
                            if (!btn_in[b]) begin
                                db_st[b]  <= RELEASED;
                                db_cnt[b] <= '0;
                            end else if (press_ev[b]) begin
                                db_st[b]  <= PRESSED;
                                db_cnt[b] <= '0;
                            end else begin
                                db_cnt[b] <= db_cnt[b] + 4'd1;
                            end
                        PRESSED:
                            if (!btn_in[b]) begin
                                if (DEB == 4'd1) begin
                                    db_st[b] <= RELEASED;
                                end else begin
                                    db_st[b]  <= ARM_RELEASE;
                                    db_cnt[b] <= 4'd1;
                                end
                            end
                        ARM_RELEASE:
                            if (btn_in[b]) begin
                                db_st[b]  <= PRESSED;
                                db_cnt[b] <= '0;
                            end else if ((db_cnt[b] + 4'd1) == DEB) begin
                                db_st[b]  <= RELEASED;
                                db_cnt[b] <= '0;
                            end else begin
                                db_cnt[b] <= db_cnt[b] + 4'd1;
                            end
                        default: begin
                            db_st[b]  <= RELEASED;
                            db_cnt[b] <= '0;
                        end
                    endcase
                end

                fcnt <= auto_en ? fcnt + 16'd1 : '0;

                if (pend_load) begin
                    rule_tab[rule_idx] <= pend_data;
                    rule      <= pend_data;
                    pend_load <= 1'b0;
                    fcnt      <= '0;
                    seed_req  <= 1'b1;
                end else if (press_ev[0] || (auto_ev && !press_ev[1])) begin
                    rule_idx <= idx_fwd;
                    rule     <= rule_tab[idx_fwd];
                    fcnt     <= '0;
                    seed_req <= 1'b1;
                end else if (press_ev[1]) begin
                    rule_idx <= idx_back;
                    rule     <= rule_tab[idx_back];
                    fcnt     <= '0;
                    seed_req <= 1'b1;
                end
            end else if (!auto_en) begin
                fcnt <= '0;
            end

            // Placed last so a load arriving on an applying tick survives the clear.
            if (load.load_valid && !pend_load) begin
                pend_load <= 1'b1;
                pend_data <= load.load_data;
            end
        end
    end
endmodule

// File: tb/tb_ca_rule_sequencer.sv
// Directed plus randomized bench for ca_rule_sequencer against a behavioural model.
module tb_ca_rule_sequencer;
    localparam int unsigned N   = 8;
    localparam int unsigned FPR = 4;
    localparam int unsigned DEB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] rule;
    logic [2:0] rule_idx;
    logic       seed_req;

    ca_rule_sequencer_if lif ();

    ca_rule_sequencer #(
        .NUM_RULES(N),
        .FRAMES_PER_RULE(FPR),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en(auto_en),
        .load(lif.slave),
        .rule(rule),
        .rule_idx(rule_idx),
        .seed_req(seed_req)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: debouncing is a run length of samples that differ
    // from the accepted level; the stable level flips when the run hits DEB.
    int m_tab [N];
    int m_idx, m_rule, m_pdata, m_frames;
    bit m_seed, m_pend;
    bit m_stable [2];
    int m_run [2];

    function automatic int def_rule(input int i);
        int d [8] = '{30, 110, 22, 73, 90, 146, 105, 102};
        return (i < 8) ? d[i] : 0;
    endfunction

    task automatic model_step();
        bit lvl [2];
        bit ev [2];
        bit pend_old, auto_ev, applied;
        if (reset) begin
            for (int i = 0; i < N; i++) m_tab[i] = def_rule(i);
            m_idx = 0; m_rule = 30; m_seed = 0; m_pend = 0; m_pdata = 0; m_frames = 0;
            for (int b = 0; b < 2; b++) begin m_stable[b] = 0; m_run[b] = 0; end
            return;
        end
        pend_old = m_pend;
        applied  = 0;
        lvl[0] = btn_next; lvl[1] = btn_prev;
        ev[0] = 0; ev[1] = 0;
        if (frame_tick) begin
            for (int b = 0; b < 2; b++) begin
                if (lvl[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = lvl[b];
                        m_run[b] = 0;
                        ev[b] = lvl[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            auto_ev  = auto_en && (m_frames + 1 >= FPR);
            m_frames = auto_en ? m_frames + 1 : 0;
            if (m_pend) begin
                m_tab[m_idx] = m_pdata;
                applied = 1;
            end else if (ev[0]) begin
                m_idx = (m_idx + 1) % N; applied = 1;
            end else if (ev[1]) begin
                m_idx = (m_idx + N - 1) % N; applied = 1;
            end else if (auto_ev) begin
                m_idx = (m_idx + 1) % N; applied = 1;
            end
            if (applied) begin
                m_rule = m_tab[m_idx];
                m_pend = 0;
                m_frames = 0;
            end
        end else if (!auto_en) begin
            m_frames = 0;
        end
        m_seed = applied;
        if (lif.load_valid && !pend_old) begin
            m_pend  = 1;
            m_pdata = lif.load_data;
        end
    endtask

    task automatic step(input bit ft);
        frame_tick = ft;
        model_step();
        @(posedge clk);
        #1;
        check("rule", rule, m_rule);
        check("rule_idx", rule_idx, m_idx);
        check("seed_req", seed_req, m_seed);
        check("load_ready", lif.load_ready, !m_pend);
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(1'b1);
            repeat (3) step(1'b0);
        end
    endtask

    bit ft, last_ft;

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = 8'h00;

        step(0); step(0);
        check("rst_rule", rule, 30);
        check("rst_idx", rule_idx, 0);
        check("rst_ready", lif.load_ready, 1);
        check("rst_seed", seed_req, 0);
        reset = 1'b0;

        frames(10);
        check("idle_rule", rule, 30);
        check("idle_idx", rule_idx, 0);

        btn_next = 1'b1;
        frames(2);
        step(1);
        check("next_rule", rule, 110);
        check("next_idx", rule_idx, 1);
        check("next_seed", seed_req, 1);
        repeat (3) step(0);
        frames(20);
        check("held_idx", rule_idx, 1);
        btn_next = 1'b0;
        frames(3);

        btn_next = 1'b1; frames(2); btn_next = 1'b0; frames(3);
        check("glitch_idx", rule_idx, 1);

        btn_prev = 1'b1; frames(3); btn_prev = 1'b0; frames(3);
        check("prev_idx", rule_idx, 0);
        btn_prev = 1'b1; frames(3);
        check("wrap_idx", rule_idx, 7);
        check("wrap_rule", rule, 102);
        btn_prev = 1'b0; frames(3);
        btn_next = 1'b1; frames(3); btn_next = 1'b0; frames(3);
        check("back0_idx", rule_idx, 0);

        step(0);
        lif.load_valid = 1'b1; lif.load_data = 8'h5A;
        step(0);
        check("load_ready_low", lif.load_ready, 0);
        check("load_rule_hold", rule, 30);
        lif.load_data = 8'h11;
        step(0);
        check("load_refused", lif.load_ready, 0);
        lif.load_valid = 1'b0;
        step(0);
        step(1);
        check("load_rule", rule, 8'h5A);
        check("load_seed", seed_req, 1);
        repeat (3) step(0);
        btn_next = 1'b1; frames(3); btn_next = 1'b0; frames(3);
        check("after_load_next", rule, 110);
        btn_prev = 1'b1; frames(3); btn_prev = 1'b0; frames(3);
        check("table_persist", rule, 8'h5A);

        reset = 1'b1; step(0); reset = 1'b0;
        auto_en = 1'b1;
        frames(3);
        check("auto_wait", rule_idx, 0);
        frames(1);
        check("auto1_rule", rule, 110);
        frames(4);
        check("auto2_rule", rule, 22);
        frames(1);
        btn_next = 1'b1;
        frames(3);
        check("auto_coinc_idx", rule_idx, 3);
        frames(20);
        check("auto_wrap_idx", rule_idx, 0);
        check("auto_wrap_rule", rule, 30);
        btn_next = 1'b0; auto_en = 1'b0;
        frames(3);

        btn_next = 1'b1;
        frames(2);
        lif.load_valid = 1'b1; lif.load_data = 8'h77;
        step(0);
        lif.load_valid = 1'b0;
        step(0);
        step(1);
        check("load_beats_next_idx", rule_idx, 0);
        check("load_beats_next_rule", rule, 8'h77);
        repeat (3) step(0);
        frames(3);
        check("no_queued_next", rule_idx, 0);
        btn_next = 1'b0; frames(3);

        lif.load_valid = 1'b1; lif.load_data = 8'h33;
        step(0);
        lif.load_valid = 1'b0;
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        check("rst2_rule", rule, 30);
        check("rst2_ready", lif.load_ready, 1);
        frames(5);
        check("rst2_hold", rule, 30);

        last_ft = 0;
        for (int i = 0; i < 1500; i++) begin
            ft = !last_ft && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 15) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
            lif.load_valid = ($urandom_range(0, 9) == 0);
            lif.load_data  = 8'($urandom);
            reset = ($urandom_range(0, 250) == 0);
            step(ft);
            last_ft = ft;
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
